// File: rtl/cnn_layer_accel_pkg.sv
// cnn_layer_accel_pkg: shared types and field widths for the CNN layer accelerator.
package cnn_layer_accel_pkg;
    localparam int HDR_W = 6;
    localparam int CFG_W = 16;
    typedef enum logic [1:0] {IDLE, HDR, LOAD, EXEC} state_t;
endpackage

// File: rtl/cnn_layer_accel_wht_cfg_ctrl.sv
// cnn_layer_accel_wht_cfg_ctrl: loads the 3x3 weight table from a config word stream and sequences kernel passes.
`ifndef MAX_BRAM_3x3_KERNELS
`define MAX_BRAM_3x3_KERNELS 64
`endif
module cnn_layer_accel_wht_cfg_ctrl
    import cnn_layer_accel_pkg::*;
#(
    parameter int C_WEIGHTS_PER_KERNEL = 9,
    parameter int C_MAX_KERNELS = `MAX_BRAM_3x3_KERNELS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             job_start,
    input  logic             cfg_in_valid,
    input  logic [CFG_W-1:0] cfg_in_data,
    output logic             cfg_in_ready,
    output logic             config_mode,
    output logic             job_accept,
    output logic             kernel_config_valid,
    output logic             wht_config_wren,
    output logic [CFG_W-1:0] config_data,
    output logic [CFG_W-1:0] wht_config_data,
    input  logic             pass_done,
    output logic             next_kernel,
    output logic             exec_ready,
    output logic             job_done,
    output logic             cfg_error
);
    localparam int WC_W = C_WEIGHTS_PER_KERNEL > 1 ? $clog2(C_WEIGHTS_PER_KERNEL) : 1;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(C_WEIGHTS_PER_KERNEL - 1);
    localparam logic [CFG_W-1:0] HDR_MAX = CFG_W'(C_MAX_KERNELS - 1);

    state_t state, state_n;
    logic [WC_W-1:0] word_cnt;
    logic [HDR_W-1:0] kern_cnt, pass_cnt, last_kern;
    logic start, xfer, hdr_ok, hdr_bad, load_xfer, load_last, pass, exec_last;
    logic accept_d, mode_d, exec_d;

    assign cfg_in_ready = !rst && (state == HDR || state == LOAD);
    assign start = state == IDLE && job_start;
    assign xfer = cfg_in_valid && cfg_in_ready;
    // The full header word is range-checked, not just the 6-bit field.
    assign hdr_ok = state == HDR && xfer && cfg_in_data <= HDR_MAX;
    assign hdr_bad = state == HDR && xfer && cfg_in_data > HDR_MAX;
    assign load_xfer = state == LOAD && xfer;
    assign load_last = load_xfer && word_cnt == WC_LAST && kern_cnt == last_kern;
    assign pass = state == EXEC && pass_done;
    assign exec_last = pass && pass_cnt == last_kern;

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: state_n = job_start ? HDR : IDLE;
            HDR: state_n = hdr_ok ? LOAD : hdr_bad ? IDLE : HDR;
            LOAD: state_n = load_last ? EXEC : LOAD;
            EXEC: state_n = exec_last ? IDLE : EXEC;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || start) begin
            word_cnt <= '0;
            kern_cnt <= '0;
            pass_cnt <= '0;
            last_kern <= '0;
        end else begin
            if (hdr_ok)
                last_kern <= cfg_in_data[HDR_W-1:0];
            if (load_xfer) begin
                word_cnt <= word_cnt == WC_LAST ? '0 : word_cnt + 1'b1;
                kern_cnt <= word_cnt == WC_LAST ? kern_cnt + 1'b1 : kern_cnt;
            end
            if (pass)
                pass_cnt <= pass_cnt + 1'b1;
        end
    end

    // config_mode stays up through the cycle that carries the final weight write.
    always_comb begin
        accept_d = start;
        mode_d = state_n == HDR || state_n == LOAD || load_last;
        exec_d = state_n == EXEC;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            job_accept <= 1'b0;
            config_mode <= 1'b0;
            kernel_config_valid <= 1'b0;
            config_data <= '0;
            cfg_error <= 1'b0;
            wht_config_wren <= 1'b0;
            wht_config_data <= '0;
            next_kernel <= 1'b0;
            job_done <= 1'b0;
            exec_ready <= 1'b0;
        end else begin
            job_accept <= accept_d;
            config_mode <= mode_d;
            kernel_config_valid <= hdr_ok;
            config_data <= hdr_ok ? {{(CFG_W - HDR_W){1'b0}}, cfg_in_data[HDR_W-1:0]} : config_data;
            cfg_error <= hdr_bad;
            wht_config_wren <= load_xfer;
            wht_config_data <= load_xfer ? cfg_in_data : wht_config_data;
            next_kernel <= pass;
            job_done <= exec_last;
            exec_ready <= exec_d;
        end
    end
endmodule

// File: tb/tb_cnn_layer_accel_wht_cfg_ctrl.sv
// tb_cnn_layer_accel_wht_cfg_ctrl: scoreboard bench comparing the weight-config controller to a job-level model.
module tb_cnn_layer_accel_wht_cfg_ctrl;
    localparam int MAXK = 64;
    localparam int WPK = 9;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic job_start = 1'b0;
    logic cfg_in_valid = 1'b0;
    logic [15:0] cfg_in_data = '0;
    logic pass_done = 1'b0;
    logic cfg_in_ready, config_mode, job_accept, kernel_config_valid, wht_config_wren;
    logic next_kernel, exec_ready, job_done, cfg_error;
    logic [15:0] config_data, wht_config_data;

    cnn_layer_accel_wht_cfg_ctrl dut (
        .clk(clk), .rst(rst), .job_start(job_start),
        .cfg_in_valid(cfg_in_valid), .cfg_in_data(cfg_in_data), .cfg_in_ready(cfg_in_ready),
        .config_mode(config_mode), .job_accept(job_accept),
        .kernel_config_valid(kernel_config_valid), .wht_config_wren(wht_config_wren),
        .config_data(config_data), .wht_config_data(wht_config_data),
        .pass_done(pass_done), .next_kernel(next_kernel), .exec_ready(exec_ready),
        .job_done(job_done), .cfg_error(cfg_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;
        logic [15:0] data;
        int cyc;
    } ev_t;
    ev_t q[$];
    int checks = 0;
    int errors = 0;
    int cycle = 0;

    // Job-level model: phase 0 idle, 1 awaiting header, 2 loading, 3 executing.
    int ph = 0;
    int m_n = 0;
    int m_words = 0;
    int m_passes = 0;
    bit m_cm = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic push(input int k, input logic [15:0] d);
        ev_t e;
        e.kind = k;
        e.data = d;
        e.cyc = cycle + 1;
        q.push_back(e);
    endtask

    task automatic see(input int k, input logic [15:0] d);
        ev_t e;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d data %0h expected none (cycle %0d)", k, d, cycle);
        end else begin
            e = q.pop_front();
            chk("event_kind", k, e.kind);
            chk("event_data", d, e.data);
            chk("event_cycle", cycle, e.cyc);
        end
    endtask

    always @(negedge clk) begin
        cycle++;
        if (job_accept) see(0, 16'h0);
        if (kernel_config_valid) see(1, config_data);
        if (cfg_error) see(2, 16'h0);
        if (wht_config_wren) see(3, wht_config_data);
        if (next_kernel) see(4, 16'h0);
        if (job_done) see(5, 16'h0);
        while (q.size() > 0 && q[0].cyc <= cycle) begin
            checks++;
            errors++;
            $display("FAIL missing_event: got none expected kind %0d data %0h (cycle %0d)", q[0].kind, q[0].data, cycle);
            void'(q.pop_front());
        end
    end

    task automatic cyc(input logic r, input logic js, input logic v, input logic [15:0] d, input logic pd);
        bit last;
        rst = r;
        job_start = js;
        cfg_in_valid = v;
        cfg_in_data = d;
        pass_done = pd;
        @(negedge clk);
        chk("cfg_in_ready", cfg_in_ready, !r && (ph == 1 || ph == 2));
        chk("exec_ready", exec_ready, ph == 3);
        chk("config_mode", config_mode, m_cm);
        @(posedge clk);
        last = 0;
        if (r) ph = 0;
        else case (ph)
            0: if (js) begin push(0, 16'h0); ph = 1; end
            1: if (v) begin
                if (int'(d) > MAXK - 1) begin push(2, 16'h0); ph = 0; end
                else begin
                    m_n = int'(d[5:0]);
                    push(1, {10'b0, d[5:0]});
                    m_words = WPK * (m_n + 1);
                    ph = 2;
                end
            end
            2: if (v) begin
                push(3, d);
                m_words--;
                if (m_words == 0) begin ph = 3; m_passes = m_n + 1; last = 1; end
            end
            default: if (pd) begin
                push(4, 16'h0);
                m_passes--;
                if (m_passes == 0) begin push(5, 16'h0); ph = 0; end
            end
        endcase
        m_cm = ph == 1 || ph == 2 || last;
        #1;
    endtask

    function automatic logic rb(input bit en);
        return en && $urandom_range(0, 1) == 1;
    endfunction

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 0, 16'($urandom), 0);
    endtask

    // vmode: 0 valid held high, 1 valid toggling 1,0,..., 2 random valid.
    task automatic job(input logic [15:0] hdr, input logic [15:0] base, input int vmode, input bit noise, input int abort_at);
        int sent = 0;
        int guard = 0;
        logic v;
        bit is_w;
        cyc(0, 1, rb(noise), 16'($urandom), rb(noise));
        while ((ph == 1 || ph == 2) && guard < 400) begin
            guard++;
            if (abort_at >= 0 && sent == abort_at) begin
                cyc(1, 0, 0, 16'h0, 0);
                cyc(1, 0, 0, 16'h0, 0);
                return;
            end
            v = vmode == 0 ? 1'b1 : vmode == 1 ? logic'(guard % 2) : rb(1);
            is_w = ph == 2 && v;
            cyc(0, rb(noise), v, ph == 1 ? hdr : v ? base + 16'(sent) : 16'($urandom), rb(noise));
            if (is_w) sent++;
        end
        guard = 0;
        while (ph == 3 && guard < 400) begin
            guard++;
            cyc(0, rb(noise), rb(noise), 16'($urandom), vmode == 0 ? 1'b1 : rb(1));
        end
        if (guard >= 400) chk("job_bound", guard, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        cyc(1, 1, 1, 16'h0001, 1);
        cyc(1, 0, 0, 16'h0, 0);
        idle(2);
        job(16'h0001, 16'h0100, 0, 0, -1);
        idle(2);
        job(16'h0001, 16'h0200, 1, 0, -1);
        idle(2);
        job(16'h0002, 16'h0300, 0, 0, -1);
        repeat (3) cyc(0, 0, 0, 16'($urandom), 1);
        job(16'h0040, 16'h0400, 0, 0, -1);
        idle(2);
        job(16'h0003, 16'h0500, 0, 0, 5);
        job(16'h0000, 16'h0600, 0, 0, -1);
        idle(2);
        job(16'h0000, 16'h0700, 2, 1, -1);
        for (int i = 0; i < 30; i++) begin
            job($urandom_range(0, 5) == 0 ? 16'($urandom_range(MAXK, 200)) : 16'($urandom_range(0, 3)),
                16'($urandom), 2, 1, $urandom_range(0, 9) == 0 ? $urandom_range(0, 12) : -1);
            idle($urandom_range(0, 2));
        end
        idle(3);
        chk("scoreboard_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
